// File: rtl/serial_word_adder.sv
// Bit-serial add/subtract over WORD_BITS-bit words, LSB first.
// Registered sum stream with word framing and overflow flags.
module serial_word_adder #(
  parameter int WORD_BITS = 4,
  parameter int SIGNED    = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bit_en,
  input  logic sync,
  input  logic sub,
  input  logic line1,
  input  logic line2,
  input  logic clr_sticky,
  output logic outp,
  output logic out_valid,
  output logic out_last,
  output logic overflw,
  output logic ovf_sticky
);

  localparam int PW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [PW-1:0] LAST = PW'(WORD_BITS - 1);

  typedef struct packed {
    logic [PW-1:0] pos;
    logic          carry;
    logic          sub_q;
  } st_t;

  st_t st;

  logic [PW-1:0] p;
  logic          first;
  logic          last;
  logic          m;
  logic          c;
  logic          b;
  logic          sum;
  logic          cout;
  logic          ovf;
  logic          ovf_nx;

  // sync restarts the word on the current bit; pos is ignored then
  always_comb begin
    p     = sync ? '0 : st.pos;
    first = (p == '0);
    last  = (p == LAST);
    m     = first ? sub : st.sub_q;
    c     = first ? sub : st.carry;
    b     = line2 ^ m;
    sum   = line1 ^ b ^ c;
    cout  = (line1 & b) | (line1 & c) | (b & c);
    if (SIGNED != 0)
      ovf = c ^ cout;
    else
      ovf = m ? ~cout : cout;
    ovf_nx = bit_en & last & ovf;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st        <= '0;
      outp      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflw   <= 1'b0;
    end else if (bit_en) begin
      outp      <= sum;
      out_valid <= 1'b1;
      st.sub_q  <= m;
      if (last) begin
        st.pos   <= '0;
        st.carry <= 1'b0;
        out_last <= 1'b1;
        overflw  <= ovf;
      end else begin
        st.pos   <= p + 1'b1;
        st.carry <= cout;
        out_last <= 1'b0;
        overflw  <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflw   <= 1'b0;
    end
  end

  // a new overflow wins over a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ovf_sticky <= 1'b0;
    else
      ovf_sticky <= (ovf_sticky & ~clr_sticky) | ovf_nx;
  end

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder, unsigned and signed
// instances driven from the same serial stimulus.
module tb_serial_word_adder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic bit_en = 1'b0;
  logic sync = 1'b0;
  logic sub = 1'b0;
  logic line1 = 1'b0;
  logic line2 = 1'b0;
  logic clr_sticky = 1'b0;

  logic u_outp, u_valid, u_last, u_ovf, u_stk;
  logic s_outp, s_valid, s_last, s_ovf, s_stk;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  serial_word_adder #(.WORD_BITS(4), .SIGNED(0)) u0 (
    .clock(clock), .reset_n(reset_n), .bit_en(bit_en),
    .sync(sync), .sub(sub), .line1(line1), .line2(line2),
    .clr_sticky(clr_sticky), .outp(u_outp),
    .out_valid(u_valid), .out_last(u_last),
    .overflw(u_ovf), .ovf_sticky(u_stk)
  );

  serial_word_adder #(.WORD_BITS(4), .SIGNED(1)) u1 (
    .clock(clock), .reset_n(reset_n), .bit_en(bit_en),
    .sync(sync), .sub(sub), .line1(line1), .line2(line2),
    .clr_sticky(clr_sticky), .outp(s_outp),
    .out_valid(s_valid), .out_last(s_last),
    .overflw(s_ovf), .ovf_sticky(s_stk)
  );

  task automatic step(input logic a, input logic b,
                      input logic s, input logic sy,
                      input logic en, input logic clr);
    @(negedge clock);
    line1 = a; line2 = b; sub = s; sync = sy;
    bit_en = en; clr_sticky = clr;
    @(posedge clock);
    #1;
    bit_en = 1'b0; sync = 1'b0; clr_sticky = 1'b0;
  endtask

  // one 4-bit word, sub only on bit 0, sync optional on bit 0
  task automatic word(input logic [3:0] a, input logic [3:0] b,
                      input logic s, input logic sy,
                      output logic [3:0] uo, output logic [3:0] so,
                      output logic [3:0] lst, output logic [3:0] uov,
                      output logic [3:0] sov, output logic [3:0] vld);
    for (int i = 0; i < 4; i++) begin
      step(a[i], b[i], (i == 0) ? s : ~s, (i == 0) ? sy : 1'b0,
           1'b1, 1'b0);
      uo[i] = u_outp; so[i] = s_outp; lst[i] = u_last;
      uov[i] = u_ovf; sov[i] = s_ovf; vld[i] = u_valid;
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({u_outp, u_valid, u_last, u_ovf, u_stk} !== 5'b0) begin
      bad++;
      $display("FAIL reset_u got=%b want=00000",
               {u_outp, u_valid, u_last, u_ovf, u_stk});
    end
    total++;
    if ({s_outp, s_valid, s_last, s_ovf, s_stk} !== 5'b0) begin
      bad++;
      $display("FAIL reset_s got=%b want=00000",
               {s_outp, s_valid, s_last, s_ovf, s_stk});
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    logic [3:0] uo, so, lst, uov, sov, vld;
    word(4'b0101, 4'b0011, 1'b0, 1'b0, uo, so, lst, uov, sov, vld);
    total++;
    if (uo !== 4'b1000) begin
      bad++; $display("FAIL add53_sum got=%b want=1000", uo);
    end
    total++;
    if (lst !== 4'b1000 || vld !== 4'b1111) begin
      bad++; $display("FAIL add53_frame last=%b valid=%b want=1000/1111", lst, vld);
    end
    total++;
    if (uov !== 4'b0000 || sov !== 4'b1000) begin
      bad++; $display("FAIL add53_ovf u=%b s=%b want=0000/1000", uov, sov);
    end
  endtask

  task automatic test_overflow_sticky;
    logic [3:0] uo, so, lst, uov, sov, vld;
    word(4'b1001, 4'b1000, 1'b0, 1'b0, uo, so, lst, uov, sov, vld);
    total++;
    if (uo !== 4'b0001 || uov !== 4'b1000 || sov !== 4'b1000) begin
      bad++;
      $display("FAIL add98 sum=%b uov=%b sov=%b want=0001/1000/1000", uo, uov, sov);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    total++;
    if (u_stk !== 1'b1 || s_stk !== 1'b1 || u_ovf !== 1'b0) begin
      bad++;
      $display("FAIL sticky_hold stk=%b%b ovf=%b want=11/0", u_stk, s_stk, u_ovf);
    end
    step(0, 0, 0, 0, 0, 1);
    total++;
    if (u_stk !== 1'b0 || s_stk !== 1'b0) begin
      bad++; $display("FAIL sticky_clr got=%b%b want=00", u_stk, s_stk);
    end
  endtask

  task automatic test_sub;
    logic [3:0] uo, so, lst, uov, sov, vld;
    word(4'b0011, 4'b0101, 1'b1, 1'b0, uo, so, lst, uov, sov, vld);
    total++;
    if (uo !== 4'b1110 || so !== 4'b1110) begin
      bad++; $display("FAIL sub35_diff u=%b s=%b want=1110", uo, so);
    end
    total++;
    if (uov !== 4'b1000 || sov !== 4'b0000) begin
      bad++; $display("FAIL sub35_ovf u=%b s=%b want=1000/0000", uov, sov);
    end
  endtask

  task automatic test_set_wins;
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1);
    total++;
    if (u_ovf !== 1'b1 || u_stk !== 1'b1) begin
      bad++; $display("FAIL set_wins ovf=%b stk=%b want=1/1", u_ovf, u_stk);
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_stall;
    logic [3:0] uo;
    logic [3:0] lst;
    logic hold_ok;
    hold_ok = 1'b1;
    step(1, 0, 0, 1, 1, 0); uo[0] = u_outp;
    step(0, 0, 0, 0, 1, 0); uo[1] = u_outp;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, 0);
      if (u_valid !== 1'b0 || u_last !== 1'b0 || u_outp !== 1'b0)
        hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok) begin
      bad++; $display("FAIL stall_idle got=0 want=1");
    end
    step(0, 0, 0, 0, 1, 0); uo[2] = u_outp; lst[2] = u_last;
    step(1, 1, 0, 0, 1, 0); uo[3] = u_outp; lst[3] = u_last;
    total++;
    if (uo !== 4'b0001 || lst[3:2] !== 2'b10 || u_ovf !== 1'b1) begin
      bad++;
      $display("FAIL stall_98 sum=%b last=%b ovf=%b want=0001/10/1", uo, lst[3:2], u_ovf);
    end
  endtask

  task automatic test_resync;
    logic [3:0] uo, so, lst, uov, sov, vld;
    logic early;
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    early = u_last | u_ovf;
    word(4'b0101, 4'b0011, 1'b0, 1'b1, uo, so, lst, uov, sov, vld);
    total++;
    if (early !== 1'b0 || uov !== 4'b0000) begin
      bad++; $display("FAIL resync_ovf early=%b uov=%b want=0/0000", early, uov);
    end
    total++;
    if (uo !== 4'b1000 || lst !== 4'b1000) begin
      bad++; $display("FAIL resync_word sum=%b last=%b want=1000/1000", uo, lst);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] uo, so, lst, uov, sov, vld;
    word(4'b0110, 4'b0001, 1'b0, 1'b0, uo, so, lst, uov, sov, vld);
    total++;
    if (uo !== 4'b0111 || lst !== 4'b1000 || uov !== 4'b0000) begin
      bad++; $display("FAIL b2b_w1 sum=%b last=%b ovf=%b want=0111/1000/0000", uo, lst, uov);
    end
    word(4'b0111, 4'b0010, 1'b1, 1'b0, uo, so, lst, uov, sov, vld);
    total++;
    if (uo !== 4'b0101 || uov !== 4'b0000 || sov !== 4'b0000) begin
      bad++; $display("FAIL b2b_w2 sum=%b uov=%b sov=%b want=0101/0000/0000", uo, uov, sov);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] uo, so, lst, uov, sov, vld;
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({u_outp, u_valid, u_last, u_ovf, u_stk} !== 5'b0) begin
      bad++;
      $display("FAIL async_rst got=%b want=00000",
               {u_outp, u_valid, u_last, u_ovf, u_stk});
    end
    @(negedge clock);
    reset_n = 1'b1;
    word(4'b0101, 4'b0011, 1'b0, 1'b0, uo, so, lst, uov, sov, vld);
    total++;
    if (uo !== 4'b1000 || lst !== 4'b1000 || uov !== 4'b0000) begin
      bad++; $display("FAIL post_rst sum=%b last=%b ovf=%b want=1000/1000/0000", uo, lst, uov);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_overflow_sticky;
    test_sub;
    test_set_wins;
    test_stall;
    test_resync;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_adder.md
# serial_word_adder

Bit-serial two-operand add/subtract engine over words of WORD_BITS bits, LSB first, one bit per enabled clock. It generalises the fixed 4-bit serial-sum state machine with a parametrised word length, per-word add/subtract selection, signed/unsigned overflow, stall and resynchronisation. It sits between the serial line receivers and the downstream serial consumer, producing a registered sum stream plus word-framing and overflow flags.

## Interface
- WORD_BITS, 4: bits per word; legal range 2..64.
- SIGNED, 0: 0 = unsigned overflow (carry/borrow out), 1 = two's-complement overflow.
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- bit_en  in  1  current line1/line2 bit is valid; 0 = stall.
- sync  in  1  with bit_en, current bit is bit 0 of a new word.
- sub  in  1  sampled on bit 0 only: 1 = line1 - line2, 0 = line1 + line2.
- line1  in  1  operand A serial bit.
- line2  in  1  operand B serial bit.
- clr_sticky  in  1  clears ovf_sticky.
- outp  out  1  registered result bit.
- out_valid  out  1  outp updated this cycle.
- out_last  out  1  outp is the MSB of a word.
- overflw  out  1  overflow of the word just completed; asserted with out_last only.
- ovf_sticky  out  1  set by any overflw, held until clr_sticky.

## Operation
- Internal state: bit position pos (0..WORD_BITS-1, clog2 width), carry register, latched sub_q.
- Bit accepted when bit_en=1. Effective position p = 0 if sync=1, else pos.
- At p=0: mode m = sub; carry-in c = sub. Otherwise m = sub_q, c = carry.
- b = line2 ^ m; sum = line1 ^ b ^ c; cout = majority(line1, b, c).
- On accept: outp <= sum; out_valid <= 1; carry <= cout; sub_q <= m.
- p < WORD_BITS-1: pos <= p+1; out_last <= 0; overflw <= 0.
- p = WORD_BITS-1: pos <= 0; carry <= 0; out_last <= 1; overflw <= ovf, where ovf = SIGNED ? (c ^ cout) : (m ? ~cout : cout).
- bit_en=0: pos, carry, sub_q, outp hold; out_valid, out_last, overflw <= 0.
- sync=1 mid-word: the partial word is abandoned with no overflw; the current bit starts a new word.
- sync with bit_en=0 is ignored.
- ovf_sticky <= (ovf_sticky & ~clr_sticky) | overflw_next. Set wins over a simultaneous clr_sticky.
- overflw is never asserted without out_last.

## Timing
- Reset (async assert, any time including mid-word): outp=0, out_valid=0, out_last=0, overflw=0, ovf_sticky=0, pos=0, carry=0, sub_q=0. The partial word is lost.
- Reset deassertion is synchronised by the surrounding design; the first edge after release can accept bit 0.
- Latency: one clock. Result bit k appears on the edge that samples input bit k.
- Word throughput: WORD_BITS enabled cycles. Stalls of any length are allowed between bits.
- Words are back-to-back: the edge completing the MSB leaves pos=0, and the next enabled bit is bit 0 of the next word without sync.
- sub changes on bits other than bit 0 have no effect.

## Test plan
- WORD_BITS=4, SIGNED=0, add: A=5 (1,0,1,0), B=3 (1,1,0,0) -> outp 0,0,0,1 (=8); out_last on the 4th; overflw=0.
- Same parameters, add 9+8: A=1,0,0,1 / B=0,0,0,1 -> outp 1,0,0,0 (=1); overflw=1 with out_last; ovf_sticky=1 until clr_sticky.
- SIGNED=1, add 5+3 -> sum 8 pattern, overflw=1. Sub 3-5 (sub=1 on bit 0) -> outp 0,1,1,1 (=-2); overflw=0. Same sub with SIGNED=0 -> overflw=1 (borrow).
- 9+8 with bit_en low for 3 cycles between bits 1 and 2 -> same outp sequence; out_valid low during the stall; overflw=1 still asserted.
- After two bits of a word, sync=1 starting 5+3 -> no overflw for the abandoned word; result 8 on the following four bits; out_last on the 4th new bit.
- reset_n pulsed low after bit 2 -> all outputs 0 immediately; the next word 5+3 -> correct sum with no leftover carry.
